ssram_arbiter: RTL

//  Shares the single SSRAM controller port between an instruction-fetch requester (A, read-only)
//  and a data requester (B, read/write). Sits between the CPU memory ports and the SSRAM

---
 rtl/ssram_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ssram_arbiter.sv
// Round-robin arbiter sharing one SSRAM controller port between a read-only fetch port (A)
// and a read/write data port (B), with id-tagged read return and per-port in-flight throttling.
module ssram_arbiter #(
    parameter int unsigned BURST_LENGTH = 4,
    parameter int unsigned MAX_INFLIGHT = 8,
    localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic          clock,
    input  logic          reset_n,

    input  logic [29:0]   a_address,
    input  logic          a_read,
    output logic          a_waitrequest,
    output logic [31:0]   a_readdata,
    output logic          a_readdatavalid,
    output logic [CW-1:0] a_inflight,

    input  logic [29:0]   b_address,
    input  logic          b_read,
    input  logic          b_write,
    input  logic [31:0]   b_writedata,
    input  logic [3:0]    b_writedatamask,
    output logic          b_waitrequest,
    output logic [31:0]   b_readdata,
    output logic          b_readdatavalid,
    output logic [CW-1:0] b_inflight,

    output logic [29:0]   mem_address,
    output logic          mem_read,
    output logic          mem_write,
    output logic [31:0]   mem_writedata,
    output logic [3:0]    mem_writedatamask,
    output logic [1:0]    mem_id,
    input  logic          mem_waitrequest,
    input  logic [31:0]   mem_readdata,
    input  logic [1:0]    mem_readdataid,

    output logic          err
);

    localparam logic [CW-1:0] BURST = CW'(BURST_LENGTH);
    // A read may start only if a full burst still fits under the ceiling.
    localparam logic [CW-1:0] LIMIT = CW'(MAX_INFLIGHT - BURST_LENGTH);

    localparam logic [1:0] ID_A = 2'd1;
    localparam logic [1:0] ID_B = 2'd2;
    localparam logic [1:0] ID_BAD = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StLockA,
        StLockB
    } state_e;

    state_e state_q, state_d;

    logic          last_b_q, last_b_d;
    logic [CW-1:0] a_cnt_q, a_cnt_d;
    logic [CW-1:0] b_cnt_q, b_cnt_d;
    logic          err_q, err_d;
    logic [31:0]   a_rdata_q, b_rdata_q;
    logic          a_rvalid_q, b_rvalid_q;

    logic a_elig, b_elig;
    logic gnt_a, gnt_b;
    logic accept;
    logic a_ret, b_ret;
    logic a_inc, b_inc;

    function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cnt,
                                                 input logic          inc,
                                                 input logic          ret);
        logic [CW-1:0] n;
        n = cnt;
        if (ret && cnt != '0) begin
            n = n - CW'(1);
        end
        if (inc) begin
            n = n + BURST;
        end
        return n;
    endfunction

    // ---------------------------------------------------------------- arbitration
    always_comb begin
        a_elig = a_read && (a_cnt_q <= LIMIT);
        b_elig = b_write || (b_read && (b_cnt_q <= LIMIT));
        gnt_a  = 1'b0;
        gnt_b  = 1'b0;
        unique case (state_q)
            StLockA: gnt_a = 1'b1;
            StLockB: gnt_b = 1'b1;
            default: begin
                gnt_a = a_elig && (!b_elig || last_b_q);
                gnt_b = b_elig && !gnt_a;
            end
        endcase
        accept = (gnt_a || gnt_b) && !mem_waitrequest;
        a_inc  = gnt_a && accept;
        b_inc  = gnt_b && b_read && accept;
        a_ret  = (mem_readdataid == ID_A);
        b_ret  = (mem_readdataid == ID_B);
    end

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            last_b_q   <= 1'b1;
            a_cnt_q    <= '0;
            b_cnt_q    <= '0;
            err_q      <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            a_cnt_q    <= a_cnt_d;
            b_cnt_q    <= b_cnt_d;
            err_q      <= err_d;
            a_rvalid_q <= a_ret;
            b_rvalid_q <= b_ret;
            if (a_ret) begin
                a_rdata_q <= mem_readdata;
            end
            if (b_ret) begin
                b_rdata_q <= mem_readdata;
            end
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_a && mem_waitrequest) begin
                    state_d = StLockA;
                end else if (gnt_b && mem_waitrequest) begin
                    state_d = StLockB;
                end
            end
            StLockA, StLockB: begin
                if (!mem_waitrequest) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (accept) begin
            last_b_d = gnt_b;
        end

        a_cnt_d = next_count(a_cnt_q, a_inc, a_ret);
        b_cnt_d = next_count(b_cnt_q, b_inc, b_ret);

        err_d = err_q;
        if ((a_ret && a_cnt_q == '0) || (b_ret && b_cnt_q == '0) ||
            (mem_readdataid == ID_BAD)) begin
            err_d = 1'b1;
        end
    end

    // ---------------------------------------------------------------- outputs
    // Request strobes are gated by reset_n so nothing reaches the controller while in reset,
    // even if a requester is still holding its request.
    always_comb begin
        mem_address       = '0;
        mem_read          = 1'b0;
        mem_write         = 1'b0;
        mem_writedata     = '0;
        mem_writedatamask = '0;
        mem_id            = 2'd0;
        if (gnt_a) begin
            mem_address = a_address;
            mem_read    = reset_n;
            mem_id      = reset_n ? ID_A : 2'd0;
        end else if (gnt_b) begin
            mem_address       = b_address;
            mem_read          = reset_n && b_read;
            mem_write         = reset_n && b_write;
            mem_writedata     = b_writedata;
            mem_writedatamask = b_writedatamask;
            mem_id            = (reset_n && b_read) ? ID_B : 2'd0;
        end
        a_waitrequest   = !(reset_n && gnt_a && accept);
        b_waitrequest   = !(reset_n && gnt_b && accept);
        a_readdata      = a_rdata_q;
        a_readdatavalid = a_rvalid_q;
        a_inflight      = a_cnt_q;
        b_readdata      = b_rdata_q;
        b_readdatavalid = b_rvalid_q;
        b_inflight      = b_cnt_q;
        err             = err_q;
    end

endmodule
